pipe_stream_checker: RTL

- Consumer end of the team's 5-bit valid/ready pipeline stream: accepts beats from a pipeline output, applies a selectable backpressure pattern on its ready output, and checks data and handshake protocol.
- Sits downstream of pipeline blocks in benches and on-chip self-test.
- Counts accepted beats, flags sequence and protocol errors, and reports pass/fail when the expected beat count is reached or a stall timeout fires.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_bp_gen.sv | 52 +++++
 rtl/pipe_stream_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-bit valid/ready pipeline stream blocks.
package pipe_pkg;

  localparam int DATA_W_DEF = 5;

  typedef enum logic [1:0] {
    BP_ALWAYS = 2'b00,
    BP_ALT    = 2'b01,
    BP_LFSR   = 2'b10,
    BP_NEVER  = 2'b11
  } bp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } chk_state_e;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_bp_gen.sv
// Backpressure pattern generator: produces the ready value to register for the next cycle.
module pipe_bp_gen
  import pipe_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  bp_mode_e i_mode,
  input  logic     i_load,
  input  logic     i_run,
  output logic     o_rdy_next
);

  logic       r_phase;
  logic [7:0] r_lfsr;
  logic       w_phase_next;
  logic [7:0] w_lfsr_next;

  // Load sets up the first RUN cycle without advancing the LFSR.
  always_comb begin
    w_phase_next = r_phase;
    w_lfsr_next  = r_lfsr;
    if (i_load) begin
      w_phase_next = 1'b1;
    end else if (i_run) begin
      w_phase_next = ~r_phase;
      w_lfsr_next  = lfsr_step(r_lfsr);
    end
  end

  always_comb begin
    o_rdy_next = 1'b0;
    case (i_mode)
      BP_ALWAYS: o_rdy_next = 1'b1;
      BP_ALT:    o_rdy_next = w_phase_next;
      BP_LFSR:   o_rdy_next = w_lfsr_next[0];
      default:   o_rdy_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_phase <= w_phase_next;
      r_lfsr  <= w_lfsr_next;
    end
  end

endmodule

// File: rtl/pipe_stream_checker.sv
// Stream consumer: applies backpressure, checks incrementing data and valid/ready protocol.
module pipe_stream_checker
  import pipe_pkg::*;
#(
  parameter int         DATA_W    = DATA_W_DEF,
  parameter int         CNT_W     = 16,
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] input_val,
  input  logic              input_valid,
  output logic              input_rdy,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  expected_count_i,
  input  logic [DATA_W-1:0] first_val_i,
  input  logic [1:0]        bp_mode_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [DATA_W-1:0] first_err_val_o
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  chk_state_e        r_state;
  bp_mode_e          r_mode;
  logic [CNT_W-1:0]  r_expected_count;
  logic [DATA_W-1:0] r_exp_val;
  logic [STALL_W-1:0] r_stall_cnt;
  logic              r_stalled;
  logic [DATA_W-1:0] r_stall_val;
  logic              r_mis_seen;
  logic              r_input_rdy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [DATA_W-1:0] r_first_err_val;

  logic               w_start;
  logic               w_run;
  logic               w_xfer;
  logic               w_mismatch;
  logic               w_proto;
  logic [CNT_W:0]     w_err_sum;
  logic [CNT_W-1:0]   w_err_next;
  logic [CNT_W-1:0]   w_beat_next;
  logic               w_last;
  logic [STALL_W-1:0] w_stall_inc;
  logic               w_timeout_hit;
  bp_mode_e           w_gen_mode;
  logic               w_rdy_next;

  assign w_start     = start_i && (r_state != ST_RUN);
  assign w_run       = (r_state == ST_RUN);
  assign w_xfer      = w_run && input_valid && r_input_rdy;
  assign w_mismatch  = w_xfer && (input_val != r_exp_val);
  // A stalled beat must stay valid with identical data on the following cycle.
  assign w_proto     = w_run && r_stalled && (!input_valid || (input_val != r_stall_val));
  assign w_err_sum   = {1'b0, r_err_cnt} + {{CNT_W{1'b0}}, w_mismatch} + {{CNT_W{1'b0}}, w_proto};
  assign w_err_next  = w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
  assign w_beat_next = r_beat_cnt + 1'b1;
  assign w_last      = w_xfer && (w_beat_next == r_expected_count);
  assign w_stall_inc = r_stall_cnt + 1'b1;
  assign w_timeout_hit = !w_xfer && (w_stall_inc == STALL_W'(TIMEOUT));
  assign w_gen_mode  = w_start ? bp_mode_e'(bp_mode_i) : r_mode;

  pipe_bp_gen #(.LFSR_SEED(LFSR_SEED)) u_bp_gen (
    .i_clk      (clk_i),
    .i_rst_n    (reset_i),
    .i_mode     (w_gen_mode),
    .i_load     (w_start),
    .i_run      (w_run),
    .o_rdy_next (w_rdy_next)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state          <= ST_IDLE;
      r_mode           <= BP_ALWAYS;
      r_expected_count <= '0;
      r_exp_val        <= '0;
      r_stall_cnt      <= '0;
      r_stalled        <= 1'b0;
      r_stall_val      <= '0;
      r_mis_seen       <= 1'b0;
      r_input_rdy      <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_beat_cnt       <= '0;
      r_err_cnt        <= '0;
      r_first_err_val  <= '0;
    end else if (r_state == ST_RUN) begin
      r_input_rdy <= w_rdy_next;
      r_err_cnt   <= w_err_next;
      r_stalled   <= input_valid && !r_input_rdy;
      r_stall_val <= input_val;
      if (w_xfer) begin
        r_beat_cnt  <= w_beat_next;
        r_exp_val   <= r_exp_val + 1'b1;
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= w_stall_inc;
      end
      if (w_mismatch && !r_mis_seen) begin
        r_first_err_val <= input_val;
        r_mis_seen      <= 1'b1;
      end
      if (w_last) begin
        r_state     <= ST_DONE;
        r_done      <= 1'b1;
        r_pass      <= (w_err_next == '0);
        r_input_rdy <= 1'b0;
      end else if (w_timeout_hit) begin
        r_state     <= ST_DONE;
        r_done      <= 1'b1;
        r_timeout   <= 1'b1;
        r_pass      <= 1'b0;
        r_input_rdy <= 1'b0;
      end
    end else if (w_start) begin
      r_mode           <= bp_mode_e'(bp_mode_i);
      r_expected_count <= expected_count_i;
      r_exp_val        <= first_val_i;
      r_stall_cnt      <= '0;
      r_stalled        <= 1'b0;
      r_mis_seen       <= 1'b0;
      r_timeout        <= 1'b0;
      r_beat_cnt       <= '0;
      r_err_cnt        <= '0;
      r_first_err_val  <= '0;
      if (expected_count_i == '0) begin
        r_state     <= ST_DONE;
        r_done      <= 1'b1;
        r_pass      <= 1'b1;
        r_input_rdy <= 1'b0;
      end else begin
        r_state     <= ST_RUN;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_input_rdy <= w_rdy_next;
      end
    end
  end

  assign input_rdy       = r_input_rdy;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign timeout_o       = r_timeout;
  assign beat_cnt_o      = r_beat_cnt;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_val_o = r_first_err_val;

endmodule
